// File: rtl/con_bridge_pkg.sv
// Shared constants for the console-to-datamem bridge: opcodes, default
// response bytes and the FSM state encoding.
package con_bridge_pkg;

   // Command opcodes received over the console link
   localparam logic [7:0] OP_WRITE = 8'h57;   // 'W'
   localparam logic [7:0] OP_READ  = 8'h52;   // 'R'

   // Default response bytes
   localparam logic [7:0] DEFAULT_ACK = 8'h06;
   localparam logic [7:0] DEFAULT_NAK = 8'h15;

   // Bridge FSM state encoding
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_GET_ADDR = 3'd1;
   localparam logic [2:0] ST_GET_DATA = 3'd2;
   localparam logic [2:0] ST_MEM_WR   = 3'd3;
   localparam logic [2:0] ST_MEM_RD   = 3'd4;
   localparam logic [2:0] ST_MEM_CAP  = 3'd5;
   localparam logic [2:0] ST_SEND     = 3'd6;

   // True for bytes that open a multi-byte command
   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_WRITE) || (b == OP_READ);
   endfunction

endpackage

// File: rtl/con_word_serializer.sv
// Holds a response word and hands it to the serial transmitter one byte at a
// time, MSB first. Responses are either 1 byte (placed in word[31:24]) or 4.
//
// Handshake: tx_valid rises the cycle after load and stays high, with tx_data
// frozen, until tx_ready is seen high on a rising edge; a byte transfers only
// on tx_valid && tx_ready. done is high in the cycle whose edge transfers the
// final byte, so the owner can leave SEND on that same edge.
module con_word_serializer (
   input  logic        con_clk,
   input  logic        nrst,
   input  logic        load,
   input  logic [31:0] load_word,
   input  logic        load_len4,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        done
);

   logic [31:0] word;
   logic [1:0]  sent;
   logic        len4;

   assign tx_data = word[31:24];
   assign done    = tx_valid && tx_ready && (!len4 || (sent == 2'd3));

   // Load a new word, then shift one byte out per accepted handshake
   always_ff @(posedge con_clk or negedge nrst) begin
      if (!nrst) begin
         word     <= '0;
         sent     <= '0;
         len4     <= 1'b0;
         tx_valid <= 1'b0;
      end else if (load) begin
         word     <= load_word;
         sent     <= '0;
         len4     <= load_len4;
         tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
         if (done) begin
            // Keep the last byte on tx_data; only valid drops
            tx_valid <= 1'b0;
            sent     <= '0;
         end else begin
            word <= {word[23:0], 8'h00};
            sent <= sent + 2'd1;
         end
      end
   end

endmodule

// File: rtl/con_mem_bridge.sv
// Console-to-datamem bridge. Parses 'W' addr_hi addr_lo d3 d2 d1 d0 and
// 'R' addr_hi addr_lo commands from a byte stream, drives datamem port B and
// returns ACK, NAK or the 4 read bytes through the word serializer.
module con_mem_bridge
   import con_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK,
   parameter logic [7:0]  NAK_BYTE       = DEFAULT_NAK
) (
   input  logic        con_clk,
   input  logic        nrst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [3:0]  con_write,
   output logic [9:0]  con_addr,
   output logic [31:0] con_in,
   input  logic [31:0] con_out,
   output logic        busy,
   output logic        err_drop,
   output logic [2:0]  state_dbg
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [2:0]    state;
   logic          is_write;
   logic [1:0]    byte_idx;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          in_cmd;
   logic          drop_now;

   logic          ser_load;
   logic [31:0]   ser_word;
   logic          ser_len4;
   logic          ser_done;

   assign state_dbg = state;
   assign busy      = (state != ST_IDLE);
   assign con_write = (state == ST_MEM_WR) ? 4'hF : 4'h0;
   assign in_cmd    = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
   assign tmo_hit   = in_cmd && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign drop_now  = rx_valid && (state == ST_MEM_WR || state == ST_MEM_RD ||
                                   state == ST_MEM_CAP || state == ST_SEND);

   // Pick the response to hand to the serializer on the way into SEND
   always_comb begin
      ser_load = 1'b0;
      ser_word = '0;
      ser_len4 = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_valid && !is_opcode(rx_data)) begin
               ser_load = 1'b1;
               ser_word = {NAK_BYTE, 24'h0};
            end
         end
         ST_MEM_WR: begin
            ser_load = 1'b1;
            ser_word = {ACK_BYTE, 24'h0};
         end
         ST_MEM_CAP: begin
            ser_load = 1'b1;
            ser_word = con_out;
            ser_len4 = 1'b1;
         end
         default: ;
      endcase
   end

   // Command parser FSM, inactivity timeout and drop reporting
   always_ff @(posedge con_clk or negedge nrst) begin
      if (!nrst) begin
         state    <= ST_IDLE;
         is_write <= 1'b0;
         byte_idx <= '0;
         tmo_cnt  <= '0;
         con_addr <= '0;
         con_in   <= '0;
         err_drop <= 1'b0;
      end else begin
         err_drop <= drop_now || tmo_hit;
         case (state)
            ST_IDLE: begin
               byte_idx <= '0;
               tmo_cnt  <= '0;
               if (rx_valid) begin
                  if (is_opcode(rx_data)) begin
                     is_write <= (rx_data == OP_WRITE);
                     state    <= ST_GET_ADDR;
                  end else begin
                     state <= ST_SEND;
                  end
               end
            end
            ST_GET_ADDR: begin
               if (rx_valid) begin
                  tmo_cnt <= '0;
                  if (byte_idx == 2'd0) begin
                     con_addr[9:8] <= rx_data[1:0];
                     byte_idx      <= 2'd1;
                  end else begin
                     con_addr[7:0] <= rx_data;
                     byte_idx      <= 2'd0;
                     state         <= is_write ? ST_GET_DATA : ST_MEM_RD;
                  end
               end else if (tmo_hit) begin
                  tmo_cnt  <= '0;
                  byte_idx <= '0;
                  state    <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_GET_DATA: begin
               if (rx_valid) begin
                  tmo_cnt  <= '0;
                  con_in   <= {con_in[23:0], rx_data};
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state <= ST_MEM_WR;
                  end
               end else if (tmo_hit) begin
                  tmo_cnt  <= '0;
                  byte_idx <= '0;
                  state    <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_MEM_WR:  state <= ST_SEND;
            ST_MEM_RD:  state <= ST_MEM_CAP;
            ST_MEM_CAP: state <= ST_SEND;
            ST_SEND: begin
               if (ser_done) begin
                  state <= ST_IDLE;
               end
            end
            default:    state <= ST_IDLE;
         endcase
      end
   end

   con_word_serializer u_ser (
      .con_clk   (con_clk),
      .nrst      (nrst),
      .load      (ser_load),
      .load_word (ser_word),
      .load_len4 (ser_len4),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_con_mem_bridge.sv
// Bench for con_mem_bridge: a datamem model on port B, expected-byte and
// expected-write queues checked by one monitor every cycle, and directed
// command scenarios with hand-computed results.
module tb_con_mem_bridge;

   localparam int TMO = 16;

   logic        con_clk;
   logic        nrst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  con_write;
   logic [9:0]  con_addr;
   logic [31:0] con_in;
   logic [31:0] con_out;
   logic        busy;
   logic        err_drop;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int drops_seen = 0;

   logic [7:0]  exp_q[$];
   logic [41:0] exp_wr_q[$];
   logic [41:0] e_wr;
   logic        tx_hold = 1'b0;
   logic [7:0]  tx_prev = 8'h00;

   logic [31:0] mem [0:1023] = '{default: 32'h0};
   logic        pre_en = 1'b0;
   logic [9:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;

   con_mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .con_clk   (con_clk),
      .nrst      (nrst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .con_write (con_write),
      .con_addr  (con_addr),
      .con_in    (con_in),
      .con_out   (con_out),
      .busy      (busy),
      .err_drop  (err_drop),
      .state_dbg (state_dbg)
   );

   // Clock
   initial con_clk = 1'b0;
   always #5 con_clk = ~con_clk;

   // Datamem port B: synchronous read, full-word write, bench preload
   always @(posedge con_clk) begin
      con_out <= mem[con_addr];
      if (con_write == 4'hF) mem[con_addr] <= con_in;
      if (pre_en) mem[pre_addr] <= pre_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write and every transmitted byte must match the queues
   always @(negedge con_clk) begin
      #2;
      if (nrst) begin
         if (con_write != 4'h0) begin
            check("wr_enable", {28'h0, con_write}, 32'hF);
            check("wr_pending", {31'h0, exp_wr_q.size() != 0}, 32'h1);
            if (exp_wr_q.size() != 0) begin
               e_wr = exp_wr_q.pop_front();
               check("wr_addr", {22'h0, con_addr}, {22'h0, e_wr[41:32]});
               check("wr_data", con_in, e_wr[31:0]);
            end
         end
         if (tx_valid && tx_hold) check("tx_stable", {24'h0, tx_data}, {24'h0, tx_prev});
         if (tx_valid && tx_ready) begin
            check("tx_pending", {31'h0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
         end
         tx_hold = tx_valid && !tx_ready;
         tx_prev = tx_data;
         if (err_drop) drops_seen++;
      end
   end

   // Driver: present one byte for one cycle; starts and ends on a negedge
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge con_clk);
      rx_valid = 1'b0;
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      @(negedge con_clk);
      pre_en   = 1'b0;
   endtask

   function automatic logic sig_hit(input int sel);
      case (sel)
         0:       return tx_valid;
         1:       return con_write != 4'h0;
         2:       return err_drop;
         default: return !busy;
      endcase
   endfunction

   // Count negedges until the selected event is seen (0 = already there)
   task automatic wait_until(input int sel, input int budget, input string name, output int lat);
      lat = 0;
      while (!sig_hit(sel) && lat < budget) begin
         @(negedge con_clk);
         lat++;
      end
      if (!sig_hit(sel)) check({name, "_timeout"}, {31'h0, sig_hit(sel)}, 32'h1);
   endtask

   initial begin
      int lat;
      int d0;
      nrst     = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;

      // Reset values
      #2 nrst = 1'b0;
      #1;
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_con_write", {28'h0, con_write}, 32'h0);
      check("rst_con_addr", {22'h0, con_addr}, 32'h0);
      check("rst_con_in", con_in, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst_err_drop", {31'h0, err_drop}, 32'h0);
      repeat (2) @(negedge con_clk);
      nrst = 1'b1;
      @(negedge con_clk);

      // Write 0xDEADBEEF to 0x012, expect ACK
      exp_wr_q.push_back({10'h012, 32'hDEADBEEF});
      exp_q.push_back(8'h06);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h12);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      wait_until(1, 20, "wr_pulse", lat);
      check("wr_pulse_latency", lat + 1, 1);
      check("wr_con_addr", {22'h0, con_addr}, 32'h012);
      check("wr_con_in", con_in, 32'hDEADBEEF);
      @(negedge con_clk);
      check("wr_pulse_one_cycle", {28'h0, con_write}, 32'h0);
      wait_until(0, 20, "ack", lat);
      check("ack_latency", lat, 0);
      wait_until(3, 50, "wr_idle", lat);
      check("wr_mem", mem[10'h012], 32'hDEADBEEF);

      // Read 0x3FF
      preload(10'h3FF, 32'h01234567);
      exp_q.push_back(8'h01); exp_q.push_back(8'h23);
      exp_q.push_back(8'h45); exp_q.push_back(8'h67);
      send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF);
      wait_until(0, 20, "rd_tx", lat);
      check("rd_latency", lat + 1, 3);
      check("rd_con_addr", {22'h0, con_addr}, 32'h3FF);
      check("rd_first_byte", {24'h0, tx_data}, 32'h01);
      wait_until(3, 50, "rd_idle", lat);

      // Unknown opcode -> NAK
      exp_q.push_back(8'h15);
      send_byte(8'h41);
      check("nak_busy", {31'h0, busy}, 32'h1);
      check("nak_tx_valid", {31'h0, tx_valid}, 32'h1);
      wait_until(3, 20, "nak_idle", lat);

      // Abandoned write times out after TMO idle cycles
      d0 = drops_seen;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA);
      wait_until(2, 4 * TMO, "tmo", lat);
      check("tmo_latency", lat + 1, TMO + 1);
      @(negedge con_clk);
      check("tmo_busy", {31'h0, busy}, 32'h0);
      check("tmo_drop_count", drops_seen - d0, 1);
      repeat (5) @(negedge con_clk);
      check("tmo_no_write", mem[10'h005], 32'h0);

      // Read stalled by tx_ready, extra byte dropped during SEND
      preload(10'h155, 32'hCAFEF00D);
      exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
      exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
      d0 = drops_seen;
      tx_ready = 1'b0;
      send_byte(8'h52); send_byte(8'h01); send_byte(8'h55);
      wait_until(0, 20, "stall_tx", lat);
      check("stall_rd_latency", lat + 1, 3);
      repeat (4) @(negedge con_clk);
      send_byte(8'h99);
      repeat (5) @(negedge con_clk);
      check("stall_tx_data", {24'h0, tx_data}, 32'hCA);
      check("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
      check("stall_drop_count", drops_seen - d0, 1);
      check("stall_busy", {31'h0, busy}, 32'h1);
      tx_ready = 1'b1;
      wait_until(3, 50, "stall_idle", lat);

      // Reset in the middle of a write, then a clean write and read-back
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h20);
      send_byte(8'h11); send_byte(8'h22);
      nrst = 1'b0;
      #1;
      check("mid_rst_busy", {31'h0, busy}, 32'h0);
      check("mid_rst_con_in", con_in, 32'h0);
      check("mid_rst_con_addr", {22'h0, con_addr}, 32'h0);
      @(negedge con_clk);
      nrst = 1'b1;
      @(negedge con_clk);
      exp_wr_q.push_back({10'h021, 32'h0BADC0DE});
      exp_q.push_back(8'h06);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h21);
      send_byte(8'h0B); send_byte(8'hAD); send_byte(8'hC0); send_byte(8'hDE);
      wait_until(1, 20, "post_rst_wr", lat);
      check("post_rst_wr_latency", lat + 1, 1);
      wait_until(3, 50, "post_rst_idle", lat);
      exp_q.push_back(8'h0B); exp_q.push_back(8'hAD);
      exp_q.push_back(8'hC0); exp_q.push_back(8'hDE);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h21);
      wait_until(0, 20, "post_rst_rd", lat);
      wait_until(3, 50, "post_rst_rd_idle", lat);
      check("aborted_addr_untouched", mem[10'h020], 32'h0);

      repeat (3) @(negedge con_clk);
      check("tx_queue_drained", exp_q.size(), 0);
      check("wr_queue_drained", exp_wr_q.size(), 0);
      check("total_drops", drops_seen, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/con_mem_bridge.md
CON_MEM_BRIDGE -- requirements
Module: con_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, idle cycles between command bytes before abort.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06, write-completion response.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h15, unknown-opcode response.
REQ-004 con_clk  input  1  sole clock, rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 rx_data  input  8  command byte from serial receiver.
REQ-007 rx_valid  input  1  one-cycle strobe per rx_data byte; no backpressure.
REQ-008 tx_data  output  8  response byte to serial transmitter.
REQ-009 tx_valid  output  1  tx_data valid; held until tx_ready.
REQ-010 tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready.
REQ-011 con_write  output  4  datamem byte-write enables (port B).
REQ-012 con_addr  output  10  datamem word address (port B).
REQ-013 con_in  output  32  datamem write data.
REQ-014 con_out  input  32  datamem read data, valid one cycle after con_addr (synchronous read).
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 err_drop  output  1  one-cycle pulse when an rx byte is discarded or a timeout aborts.

Function
REQ-017 SHALL implement states IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, MEM_CAP, SEND.
REQ-018 IDLE: rx byte 8'h57 ('W') or 8'h52 ('R') -> latch opcode, GET_ADDR; any other byte -> load NAK_BYTE, SEND (1 byte).
REQ-019 GET_ADDR: two bytes, high first; con_addr = {hi[1:0], lo}; hi[7:2] ignored; then 'W' -> GET_DATA, 'R' -> MEM_RD.
REQ-020 GET_DATA: four bytes, MSB first, shifted into con_in; after 4th -> MEM_WR.
REQ-021 MEM_WR: con_write = 4'hF for exactly one cycle; then load ACK_BYTE, SEND (1 byte).
REQ-022 MEM_RD: con_addr stable, one cycle; MEM_CAP: capture con_out into tx word, SEND (4 bytes, MSB first).
REQ-023 SEND: byte counter advances only on tx_valid && tx_ready; after last byte -> IDLE next cycle.
REQ-024 con_write SHALL be 4'h0 in every state except MEM_WR.
REQ-025 con_addr and con_in SHALL hold their last value outside GET_ADDR/GET_DATA.
REQ-026 rx_valid in MEM_WR, MEM_RD, MEM_CAP or SEND SHALL drop the byte and pulse err_drop.
REQ-027 In GET_ADDR/GET_DATA, timeout counter resets on each rx_valid; reaching TIMEOUT_CYCLES-1 -> IDLE, pulse err_drop, no memory write, no response.
REQ-028 Timeout counter SHALL be held at 0 outside GET_ADDR/GET_DATA; tx_ready stall in SEND never times out.
REQ-029 Read-command latency: last addr byte to first tx_valid = 3 cycles.
REQ-030 Write-command latency: 4th data byte to con_write pulse = 1 cycle, ACK tx_valid 1 cycle after pulse.

Reset
REQ-031 nrst low SHALL immediately force IDLE, con_write=0, tx_valid=0, busy=0, err_drop=0, con_addr=0, con_in=0, tx_data=0, counters=0.
REQ-032 Reset mid-command SHALL discard partial command; no write completes after reset asserts.

Structure
REQ-033 Package con_bridge_pkg SHALL hold state enum, opcode constants 8'h57/8'h52 and default ACK/NAK values.
REQ-034 Sub-module con_word_serializer SHALL hold the 32-bit tx word, byte counter, length (1 or 4) and valid/ready logic for SEND.

Verification
REQ-035 Rx 57 00 12 DE AD BE EF -> one-cycle con_write=F, con_addr=0x012, con_in=0xDEADBEEF; tx 06.
REQ-036 Preload datamem 0x3FF=0x01234567; rx 52 FF FF -> con_addr=0x3FF; tx 01 23 45 67, first tx_valid 3 cycles after last rx.
REQ-037 Rx 41 -> tx 15, no con_write, return to IDLE.
REQ-038 Rx 57 00 05 AA, then silence TIMEOUT_CYCLES (bench param 16) -> err_drop pulse, IDLE, no write, no tx.
REQ-039 Read with tx_ready low 10 cycles; extra rx byte during SEND -> tx_data held stable, err_drop pulse, 4 bytes delivered intact.
REQ-040 nrst asserted after 2nd write data byte -> immediate IDLE; subsequent valid write completes normally.
